// File: rtl/microcode_sequencer.sv
// ---------------------------------------------------------------------------
// microcode_sequencer
//
// Purpose:
//    A small horizontal-microcode sequencer. Every instruction runs as a
//    sequence of micro-steps. Step 0 is the fetch step, which drives a fixed
//    control word and latches the opcode into the instruction register.
//    Steps 1..STEPS-1 read their control word from a writable microcode RAM
//    addressed by {opcode, step, carry flag, zero flag}. This lets one
//    opcode branch on the ALU result of an earlier instruction. A step word
//    can end its instruction early (END_BIT) and can load the carry/zero
//    flags from the ALU (FLG_BIT).
//
//    When enable is low the sequencer stalls and the microcode RAM may be
//    written. A write attempted while running is dropped and recorded in a
//    sticky error flag.
//
// Ports:
//    clk        in   1     rising-edge clock for all state
//    reset_n    in   1     asynchronous active-low reset (RAM not reset)
//    enable     in   1     1 = run, 0 = stall / program mode
//    instr      in   OPW   opcode sampled when leaving the fetch step
//    alu_c      in   1     ALU carry, loaded into c_flag on FLG_BIT words
//    alu_z      in   1     ALU zero, loaded into z_flag on FLG_BIT words
//    prog_we    in   1     microcode write strobe (honoured only when stalled)
//    prog_addr  in   AW    microcode address {opcode, step, c, z}
//    prog_data  in   CW    microcode word to write
//    ctrl       out  CW    current control word (combinational from state)
//    step       out  SW    current micro-step
//    fetch      out  1     high while step == 0
//    c_flag     out  1     registered carry flag
//    z_flag     out  1     registered zero flag
//    prog_err   out  1     sticky: a write was attempted while running
// ---------------------------------------------------------------------------
module microcode_sequencer #(
   parameter int              OPW        = 4,
   parameter int              CW         = 13,
   parameter int              STEPS      = 2,
   parameter logic [CW-1:0]   FETCH_WORD = 13'b1000000001000,
   parameter int              END_BIT    = 0,
   parameter int              FLG_BIT    = 1,
   localparam int             SW         = $clog2(STEPS),
   localparam int             AW         = OPW + SW + 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [OPW-1:0]    instr,
   input  logic              alu_c,
   input  logic              alu_z,
   input  logic              prog_we,
   input  logic [AW-1:0]     prog_addr,
   input  logic [CW-1:0]     prog_data,
   output logic [CW-1:0]     ctrl,
   output logic [SW-1:0]     step,
   output logic              fetch,
   output logic              c_flag,
   output logic              z_flag,
   output logic              prog_err
);

   // The final micro-step of every instruction. Stepping past it always
   // returns to fetch, so encodings >= STEPS can never be reached.
   localparam logic [SW-1:0] LAST_STEP  = SW'(STEPS - 1);
   localparam logic [SW-1:0] FIRST_EXEC = SW'(1);
   localparam logic [SW-1:0] FETCH_STEP = '0;

   // The two phases an instruction can be in. Fetch is step 0. Execute
   // covers every later step.
   typedef enum logic {
      PH_FETCH   = 1'b0,
      PH_EXECUTE = 1'b1
   } phase_e;

   // Sequencer state
   logic [SW-1:0]  step_q,     step_d;
   logic [OPW-1:0] ir_q,       ir_d;
   logic           c_flag_q,   c_flag_d;
   logic           z_flag_q,   z_flag_d;
   logic           prog_err_q, prog_err_d;

   // Microcode store and its read path
   logic [CW-1:0]  ucode_mem [2**AW];
   logic [AW-1:0]  rd_addr;
   logic [CW-1:0]  rd_word;
   logic           mem_write;
   phase_e         phase;

   assign phase     = (step_q == FETCH_STEP) ? PH_FETCH : PH_EXECUTE;
   assign rd_addr   = {ir_q, step_q, c_flag_q, z_flag_q};
   assign rd_word   = ucode_mem[rd_addr];
   assign mem_write = prog_we & ~enable;

   // Microcode RAM write port. The RAM has no reset: its contents survive
   // reset, so a program loaded once keeps working across resets. Writes
   // are accepted only while stalled, so the running control word never
   // changes under the sequencer.
   always_ff @(posedge clk) begin
      if (mem_write) begin
         ucode_mem[prog_addr] <= prog_data;
      end
   end

   // Control word selection. This path is purely combinational from the
   // registered state, so a new step's word appears with no extra cycle of
   // latency. A stalled sequencer drives all-zero so the datapath idles.
   always_comb begin
      ctrl = '0;
      if (enable) begin
         case (phase)
            PH_FETCH:   ctrl = FETCH_WORD;
            PH_EXECUTE: ctrl = rd_word;
            default:    ctrl = '0;
         endcase
      end
   end

   // Next-state logic. Flag loading and step advance are evaluated
   // independently, so one edge can both load flags and move to another
   // step. Flags loaded on the last step are used only from the next
   // instruction's address onward, because the current word has already
   // been driven from the old flags. END_BIT is looked at only in the
   // execute phase. The fixed fetch word can never end an instruction.
   always_comb begin
      step_d     = step_q;
      ir_d       = ir_q;
      c_flag_d   = c_flag_q;
      z_flag_d   = z_flag_q;
      prog_err_d = prog_err_q | (prog_we & enable);

      if (enable) begin
         if (ctrl[FLG_BIT]) begin
            c_flag_d = alu_c;
            z_flag_d = alu_z;
         end

         case (phase)
            PH_FETCH: begin
               ir_d   = instr;
               step_d = FIRST_EXEC;
            end
            PH_EXECUTE: begin
               if ((step_q == LAST_STEP) || ctrl[END_BIT]) begin
                  step_d = FETCH_STEP;
               end else begin
                  step_d = step_q + FIRST_EXEC;
               end
            end
            default: begin
               step_d = FETCH_STEP;
            end
         endcase
      end
   end

   // State register. Reset aborts any instruction in progress at once, so
   // the first enabled edge after release always performs a fetch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         step_q     <= FETCH_STEP;
         ir_q       <= '0;
         c_flag_q   <= 1'b0;
         z_flag_q   <= 1'b0;
         prog_err_q <= 1'b0;
      end else begin
         step_q     <= step_d;
         ir_q       <= ir_d;
         c_flag_q   <= c_flag_d;
         z_flag_q   <= z_flag_d;
         prog_err_q <= prog_err_d;
      end
   end

   assign step     = step_q;
   assign fetch    = (step_q == FETCH_STEP);
   assign c_flag   = c_flag_q;
   assign z_flag   = z_flag_q;
   assign prog_err = prog_err_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// ---------------------------------------------------------------------------
// tb_microcode_sequencer
//
// Drives two sequencer instances from shared stimulus: one with the default
// two steps per instruction, and one with four steps so that early-end and
// the longer step sequences are exercised. Each instance has its own
// microcode address bus, because the address layout depends on the step
// width. A reference model at instruction level predicts every output for
// every cycle and queues the prediction. A separate monitor pops the
// predictions on the falling edge and compares them.
// ---------------------------------------------------------------------------
module tb_microcode_sequencer;

   localparam logic [12:0] FETCH_WORD = 13'b1000000001000;
   localparam logic [12:0] WORD_A     = 13'b0001001000010;
   localparam logic [12:0] WORD_X     = 13'b0101010101000;
   localparam logic [12:0] WORD_Y     = 13'b0010101010100;
   localparam logic [12:0] WORD_END   = 13'b0000000000001;
   localparam logic [12:0] WORD_PLAIN = 13'b0000000000100;

   logic        clk = 1'b0;
   logic        reset_n, enable, alu_c, alu_z, prog_we;
   logic [3:0]  instr;
   logic [6:0]  prog_addr2;
   logic [7:0]  prog_addr4;
   logic [12:0] prog_data;

   logic [12:0] ctrl2, ctrl4;
   logic [0:0]  step2;
   logic [1:0]  step4;
   logic        fetch2, fetch4, c2, c4, z2, z4, err2, err4;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [12:0] ctrl;
      logic [3:0]  step;
      logic        fetch;
      logic        c;
      logic        z;
      logic        err;
   } exp_t;

   exp_t q2[$];
   exp_t q4[$];

   // Reference model state, one slot per instance (0: 2 steps, 1: 4 steps)
   int          m_step [2];
   int          m_ir   [2];
   bit          m_c    [2];
   bit          m_z    [2];
   bit          m_err  [2];
   logic [12:0] m_ctrl [2];
   logic [12:0] m_ram  [2][256];

   always #5 clk = ~clk;

   microcode_sequencer #(
      .OPW(4), .CW(13), .STEPS(2), .FETCH_WORD(13'b1000000001000),
      .END_BIT(0), .FLG_BIT(1)
   ) dut2 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .instr(instr),
      .alu_c(alu_c), .alu_z(alu_z), .prog_we(prog_we),
      .prog_addr(prog_addr2), .prog_data(prog_data),
      .ctrl(ctrl2), .step(step2), .fetch(fetch2),
      .c_flag(c2), .z_flag(z2), .prog_err(err2)
   );

   microcode_sequencer #(
      .OPW(4), .CW(13), .STEPS(4), .FETCH_WORD(13'b1000000001000),
      .END_BIT(0), .FLG_BIT(1)
   ) dut4 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .instr(instr),
      .alu_c(alu_c), .alu_z(alu_z), .prog_we(prog_we),
      .prog_addr(prog_addr4), .prog_data(prog_data),
      .ctrl(ctrl4), .step(step4), .fetch(fetch4),
      .c_flag(c4), .z_flag(z4), .prog_err(err4)
   );

   function automatic int stepsOf(int k);
      return (k == 0) ? 2 : 4;
   endfunction

   function automatic int swOf(int k);
      return (k == 0) ? 1 : 2;
   endfunction

   // Microcode address {opcode, step, c, z} built arithmetically
   function automatic int addrOf(int k, int op, int st, int c, int z);
      return (((op << swOf(k)) + st) * 4) + (c * 2) + z;
   endfunction

   task automatic modelReset();
      for (int k = 0; k < 2; k++) begin
         m_step[k] = 0;
         m_ir[k]   = 0;
         m_c[k]    = 1'b0;
         m_z[k]    = 1'b0;
         m_err[k]  = 1'b0;
      end
   endtask

   function automatic logic [12:0] modelCtrl(int k);
      if (!enable) return 13'd0;
      if (m_step[k] == 0) return FETCH_WORD;
      return m_ram[k][addrOf(k, m_ir[k], m_step[k], int'(m_c[k]), int'(m_z[k]))];
   endfunction

   // One rising edge of the instruction-level model, using the inputs held
   // across that edge and the control word that was showing before it.
   task automatic modelEdge();
      logic [12:0] cw;
      int          wa;
      if (!reset_n) return;
      for (int k = 0; k < 2; k++) begin
         cw = m_ctrl[k];
         wa = (k == 0) ? int'(prog_addr2) : int'(prog_addr4);
         if (prog_we) begin
            if (enable) m_err[k] = 1'b1;
            else        m_ram[k][wa] = prog_data;
         end
         if (enable) begin
            if (cw[1]) begin
               m_c[k] = alu_c;
               m_z[k] = alu_z;
            end
            if (m_step[k] == 0) begin
               m_ir[k]   = int'(instr);
               m_step[k] = 1;
            end else if (m_step[k] == stepsOf(k) - 1 || cw[0]) begin
               m_step[k] = 0;
            end else begin
               m_step[k] = m_step[k] + 1;
            end
         end
      end
   endtask

   task automatic pushExpected(input bit replaceTail);
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         e.ctrl    = modelCtrl(k);
         m_ctrl[k] = e.ctrl;
         e.step    = 4'(m_step[k]);
         e.fetch   = (m_step[k] == 0);
         e.c       = m_c[k];
         e.z       = m_z[k];
         e.err     = m_err[k];
         if (k == 0) begin
            if (replaceTail && q2.size() > 0) q2[q2.size()-1] = e;
            else q2.push_back(e);
         end else begin
            if (replaceTail && q4.size() > 0) q4[q4.size()-1] = e;
            else q4.push_back(e);
         end
      end
   endtask

   task automatic cmp(input string name, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s (STEPS=%0d) at %0t: actual=0x%0h required=0x%0h",
                  name, stepsOf(k), $time, act, exp);
      end
   endtask

   task automatic checkOutput(input int k, input exp_t e);
      if (k == 0) begin
         cmp("ctrl",     k, 32'(ctrl2),  32'(e.ctrl));
         cmp("step",     k, 32'(step2),  32'(e.step));
         cmp("fetch",    k, 32'(fetch2), 32'(e.fetch));
         cmp("c_flag",   k, 32'(c2),     32'(e.c));
         cmp("z_flag",   k, 32'(z2),     32'(e.z));
         cmp("prog_err", k, 32'(err2),   32'(e.err));
      end else begin
         cmp("ctrl",     k, 32'(ctrl4),  32'(e.ctrl));
         cmp("step",     k, 32'(step4),  32'(e.step));
         cmp("fetch",    k, 32'(fetch4), 32'(e.fetch));
         cmp("c_flag",   k, 32'(c4),     32'(e.c));
         cmp("z_flag",   k, 32'(z4),     32'(e.z));
         cmp("prog_err", k, 32'(err4),   32'(e.err));
      end
   endtask

   // Advance one clock: settle the model on the edge, then drive the next
   // inputs and queue what the outputs must show for them.
   task automatic applyStimulus(input bit rn, input bit en, input logic [3:0] ins,
                                input bit ac, input bit az, input bit we,
                                input logic [6:0] a2, input logic [7:0] a4,
                                input logic [12:0] d);
      @(posedge clk);
      #1;
      modelEdge();
      reset_n    = rn;
      enable     = en;
      instr      = ins;
      alu_c      = ac;
      alu_z      = az;
      prog_we    = we;
      prog_addr2 = a2;
      prog_addr4 = a4;
      prog_data  = d;
      if (!rn) modelReset();
      pushExpected(1'b0);
   endtask

   task automatic runCycle(input logic [3:0] ins, input bit ac, input bit az);
      applyStimulus(1'b1, 1'b1, ins, ac, az, 1'b0, 7'd0, 8'd0, 13'd0);
   endtask

   task automatic progWrite(input int op, input int st, input int c, input int z,
                            input logic [12:0] d);
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1,
                    7'(addrOf(0, op, st, c, z)), 8'(addrOf(1, op, st, c, z)), d);
   endtask

   task automatic resetPulse();
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 7'd0, 8'd0, 13'd0);
   endtask

   // Assert reset between clock edges and replace this cycle's prediction
   task automatic asyncReset();
      #1;
      reset_n = 1'b0;
      modelReset();
      pushExpected(1'b1);
   endtask

   // Monitor: compares the queued predictions against the outputs
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q2.size() > 0) begin
            e = q2.pop_front();
            checkOutput(0, e);
         end
         if (q4.size() > 0) begin
            e = q4.pop_front();
            checkOutput(1, e);
         end
      end
   end

   initial begin
      reset_n = 1'b0; enable = 1'b1; instr = 4'd0; alu_c = 1'b0; alu_z = 1'b0;
      prog_we = 1'b0; prog_addr2 = 7'd0; prog_addr4 = 8'd0; prog_data = 13'd0;
      modelReset();
      for (int k = 0; k < 2; k++) m_ctrl[k] = FETCH_WORD;

      // Reset with enable high shows the fetch word
      applyStimulus(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 7'd0, 8'd0, 13'd0);
      #1;
      cmp("reset_ctrl",  0, 32'(ctrl2),  32'(FETCH_WORD));
      cmp("reset_step",  0, 32'(step2),  32'd0);
      cmp("reset_fetch", 0, 32'(fetch2), 32'd1);
      cmp("reset_flags", 0, {30'd0, c2, z2}, 32'd0);
      cmp("reset_ctrl",  1, 32'(ctrl4),  32'(FETCH_WORD));

      // Stalled: ctrl goes to zero
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 7'd0, 8'd0, 13'd0);
      #1;
      cmp("stall_ctrl", 0, 32'(ctrl2), 32'd0);

      // Fill both RAMs with random words so every address is defined
      for (int a = 0; a < 256; a++) begin
         applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1,
                       7'(a), 8'(a), 13'($urandom));
      end

      // Program and execute a single two-step instruction
      progWrite(2, 1, 0, 0, WORD_A);
      resetPulse();
      runCycle(4'b0010, 1'b0, 1'b0);
      #1;
      cmp("exec_c0_ctrl", 0, 32'(ctrl2), 32'(FETCH_WORD));
      runCycle(4'd0, 1'b0, 1'b0);
      #1;
      cmp("exec_c1_ctrl", 0, 32'(ctrl2), 32'(WORD_A));
      cmp("exec_c1_step", 0, 32'(step2), 32'd1);
      runCycle(4'd0, 1'b0, 1'b0);
      #1;
      cmp("exec_c2_step", 0, 32'(step2), 32'd0);

      // Flag branch: carry set by an earlier instruction selects X over Y
      progWrite(8, 1, 1, 0, WORD_X);
      progWrite(8, 1, 0, 0, WORD_Y);
      resetPulse();
      runCycle(4'b0010, 1'b0, 1'b0);
      runCycle(4'd0, 1'b1, 1'b0);
      runCycle(4'b1000, 1'b0, 1'b0);
      #1;
      cmp("branch_cflag", 0, 32'(c2), 32'd1);
      runCycle(4'd0, 1'b0, 1'b0);
      #1;
      cmp("branch_ctrl", 0, 32'(ctrl2), 32'(WORD_X));

      // A write while running is dropped and latches a sticky error
      resetPulse();
      applyStimulus(1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b1,
                    7'(addrOf(0, 2, 1, 0, 0)), 8'(addrOf(1, 2, 1, 0, 0)), 13'h1FFF);
      #1;
      cmp("illegal_err_before", 0, 32'(err2), 32'd0);
      runCycle(4'd0, 1'b0, 1'b0);
      #1;
      cmp("illegal_err_set", 0, 32'(err2), 32'd1);
      cmp("illegal_ram_kept", 0, 32'(ctrl2), 32'(WORD_A));
      for (int i = 0; i < 3; i++) begin
         runCycle(4'd0, 1'b0, 1'b0);
         #1;
         cmp("illegal_err_sticky", 0, 32'(err2), 32'd1);
      end
      resetPulse();
      #1;
      cmp("illegal_err_cleared", 0, 32'(err2), 32'd0);

      // Early end versus full length on the four-step instance
      progWrite(5, 1, 0, 0, WORD_END);
      for (int s = 1; s < 4; s++) progWrite(6, s, 0, 0, WORD_PLAIN);
      resetPulse();
      runCycle(4'd5, 1'b0, 1'b0);
      #1;
      cmp("early_step0", 1, 32'(step4), 32'd0);
      runCycle(4'd0, 1'b0, 1'b0);
      #1;
      cmp("early_step1", 1, 32'(step4), 32'd1);
      runCycle(4'd6, 1'b0, 1'b0);
      #1;
      cmp("early_back0", 1, 32'(step4), 32'd0);
      for (int s = 1; s <= 4; s++) begin
         runCycle(4'd0, 1'b0, 1'b0);
         #1;
         cmp("full_step", 1, 32'(step4), 32'(s % 4));
      end

      // Reset in the middle of an instruction
      resetPulse();
      runCycle(4'b0010, 1'b0, 1'b0);
      runCycle(4'd0, 1'b1, 1'b1);
      runCycle(4'b0010, 1'b0, 1'b0);
      runCycle(4'd0, 1'b0, 1'b0);
      #1;
      cmp("midreset_pre_step", 0, 32'(step2), 32'd1);
      cmp("midreset_pre_flags", 0, {30'd0, c2, z2}, 32'd3);
      asyncReset();
      #1;
      cmp("midreset_step",  0, 32'(step2), 32'd0);
      cmp("midreset_flags", 0, {30'd0, c2, z2}, 32'd0);
      applyStimulus(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 7'd0, 8'd0, 13'd0);
      runCycle(4'b0010, 1'b0, 1'b0);
      #1;
      cmp("midreset_fetch", 0, 32'(ctrl2), 32'(FETCH_WORD));
      runCycle(4'd0, 1'b0, 1'b0);
      #1;
      cmp("midreset_ram_kept", 0, 32'(ctrl2), 32'(WORD_A));

      // Randomized operation against the model
      for (int i = 0; i < 3000; i++) begin
         bit rn, en, we;
         rn = ($urandom_range(0, 199) != 0);
         en = ($urandom_range(0, 7) != 0);
         we = rn && ($urandom_range(0, 9) == 0);
         applyStimulus(rn, en, 4'($urandom), 1'($urandom), 1'($urandom), we,
                       7'($urandom), 8'($urandom), 13'($urandom));
      end

      repeat (3) @(negedge clk);
      cmp("queue_drained", 0, 32'(q2.size() + q4.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
